// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;

    // Access size encoding; 2'b11 is not a legal size and is reported as misaligned.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // True when the access cannot be served by a single aligned word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = offset[0];
            WORD:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and dmem port bundle of the load/store unit.
// slave = the load/store unit itself, master = datapath plus memory.
interface dmem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
    );

endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane logic: extract/extend a loaded lane and merge
// store data into the addressed lane(s) of a read word (little-endian).
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] rd_word,
    input  logic [WORD_W-1:0] new_data,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] ext_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [WORD_W-1:0] shifted_word;
    logic [BYTE_W-1:0] lane_byte;
    logic [HALF_W-1:0] lane_half;
    logic [WORD_W-1:0] repl_data;
    logic [LANES-1:0]  lane_sel;

    // Pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        shifted_word = rd_word >> {offset, 3'b000};
        lane_byte    = shifted_word[BYTE_W-1:0];
        lane_half    = offset[1] ? rd_word[WORD_W-1:HALF_W] : rd_word[HALF_W-1:0];
        case (size)
            BYTE:    ext_data = {{(WORD_W-BYTE_W){~is_unsigned & lane_byte[BYTE_W-1]}}, lane_byte};
            HALF:    ext_data = {{(WORD_W-HALF_W){~is_unsigned & lane_half[HALF_W-1]}}, lane_half};
            default: ext_data = rd_word;
        endcase
    end

    // Replicate the right-aligned store data across every lane it could land in.
    always_comb begin
        case (size)
            BYTE:    repl_data = {LANES{new_data[BYTE_W-1:0]}};
            HALF:    repl_data = {2{new_data[HALF_W-1:0]}};
            default: repl_data = new_data;
        endcase
    end

    // Per-lane select: only addressed lanes take new data, the rest keep the old word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_sel[gi] = (size == BYTE) ? (offset == 2'(gi)) :
                                  (size == HALF) ? (offset[1] == (gi >= 2)) :
                                                   1'b1;
            assign merged_word[gi*BYTE_W +: BYTE_W] = lane_sel[gi] ?
                                                      repl_data[gi*BYTE_W +: BYTE_W] :
                                                      rd_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: serves byte/half/word accesses against a word-only dmem,
// using read-modify-write for sub-word stores. One request in flight.
module dmem_lsu
    import dmem_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    dmem_lsu_if.slave bus
);

    lsu_state_t  state_reg, state_next;

    // Latched request. wdata_reg first holds the store data and, after READ,
    // the merged word that WRITE puts on the bus.
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic        we_reg;
    logic        uns_reg;
    logic [31:0] wdata_reg;

    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;

    logic        req_bad;
    logic [31:0] ext_data;
    logic [31:0] merged_word;
    logic [31:0] aligned_addr;

    assign req_bad      = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign aligned_addr = {addr_reg[31:2], 2'b00};

    dmem_lane_merge u_lane_merge (
        .rd_word     (bus.mem_rd),
        .new_data    (wdata_reg),
        .offset      (addr_reg[1:0]),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_next = RESP;
                    end else if (bus.req_we && (bus.req_size == WORD)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture and response registers; response fields are only
    // non-zero during the RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_reg      <= '0;
            size_reg      <= '0;
            we_reg        <= 1'b0;
            uns_reg       <= 1'b0;
            wdata_reg     <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_reg    <= bus.req_addr;
                        size_reg    <= bus.req_size;
                        we_reg      <= bus.req_we;
                        uns_reg     <= bus.req_unsigned;
                        wdata_reg   <= bus.req_wdata;
                        rsp_err_reg <= req_bad;
                    end
                end
                READ: begin
                    if (we_reg) begin
                        wdata_reg <= merged_word;
                    end else begin
                        rsp_rdata_reg <= ext_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: the memory port is idle (all zero) outside READ/WRITE.
    always_comb begin
        bus.req_ready = reset_n && (state_reg == IDLE);
        bus.rsp_valid = (state_reg == RESP);
        bus.rsp_err   = rsp_err_reg;
        bus.rsp_rdata = rsp_rdata_reg;
        bus.mem_we    = 1'b0;
        bus.mem_a     = '0;
        bus.mem_wd    = '0;
        case (state_reg)
            READ: begin
                bus.mem_a = aligned_addr;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                bus.mem_a  = aligned_addr;
                bus.mem_wd = wdata_reg;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expected responses, a
// negedge monitor pops and compares them whenever rsp_valid is seen.
module tb_dmem_lsu;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_init = 1'b1;
    int   cyc = 0;
    int   we_cnt = 0;
    int   total = 0;
    int   passed = 0;
    exp_t exp_q[$];

    logic [31:0] mem [0:15];

    dmem_lsu_if bus();

    dmem_lsu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

    // Word memory model: combinational read, write on rising edge.
    assign bus.mem_rd = mem[bus.mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'hCAFEF00D;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[5:2]] <= bus.mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %-26s got 0x%08h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b rdata=0x%08h, expected no response",
                         bus.rsp_err, bus.rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " err"},   32'(bus.rsp_err), 32'(e.err));
                check({e.name, " rdata"}, bus.rsp_rdata, e.rdata);
                check({e.name, " lat"},   32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Present a request at the current negedge and wait for acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic push, input logic err, input logic [31:0] rdata,
                         input int lat, input string name, input logic hold,
                         output int waits);
        exp_t e;
        waits            = 0;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            total++;
            $display("FAIL %s accept: got req_ready=0 for %0d cycles, expected 1", name, waits);
            bus.req_valid = 1'b0;
            return;
        end
        if (push) begin
            e.err = err; e.rdata = rdata; e.acc = cyc; e.lat = lat; e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int w;
        int w0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'h0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst rsp_err",   32'(bus.rsp_err),   32'h0);
        check("rst rsp_rdata", bus.rsp_rdata,      32'h0);
        check("rst mem_we",    32'(bus.mem_we),    32'h0);
        check("rst mem_a",     bus.mem_a,          32'h0);
        check("rst mem_wd",    bus.mem_wd,         32'h0);
        reset_n  = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        check("post-rst req_ready", 32'(bus.req_ready), 32'h1);

        // Word store then word load
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 1'b1, 1'b0, 32'h0, 2, "st_w_8", 1'b0, w);
        drain();
        check("st_w_8 we cycles", 32'(we_cnt - w0), 32'h1);
        check("st_w_8 mem[0x8]",  mem[2], 32'h12345678);
        w0 = we_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h12345678, 2, "ld_w_8", 1'b0, w);
        drain();
        check("ld_w_8 we cycles", 32'(we_cnt - w0), 32'h0);

        // Byte store (upper data bits must be ignored) and byte loads
        w0 = we_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFFFFAB, 1'b1, 1'b0, 32'h0, 3, "st_b_9", 1'b0, w);
        drain();
        check("st_b_9 we cycles", 32'(we_cnt - w0), 32'h1);
        check("st_b_9 mem[0x8]",  mem[2], 32'h1234AB78);
        issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b1, 1'b0, 32'hFFFFFFAB, 2, "ld_b_9", 1'b0, w);
        issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b1, 1'b0, 32'h000000AB, 2, "ld_bu_9", 1'b0, w);
        drain();

        // Half store and half loads
        issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h12348001, 1'b1, 1'b0, 32'h0, 3, "st_h_a", 1'b0, w);
        drain();
        check("st_h_a mem[0x8]", mem[2], 32'h8001AB78);
        issue(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b1, 1'b0, 32'hFFFF8001, 2, "ld_h_a", 1'b0, w);
        issue(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 32'h00008001, 2, "ld_hu_a", 1'b0, w);
        drain();

        // Misaligned / illegal requests
        w0 = we_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0, 1, "ld_w_6", 1'b0, w);
        issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000BEEF, 1'b1, 1'b1, 32'h0, 1, "st_h_5", 1'b0, w);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1, "ld_sz3_0", 1'b0, w);
        drain();
        check("misaligned we cycles", 32'(we_cnt - w0), 32'h0);
        check("misaligned mem[0x4]",  mem[1], 32'hCAFEF00D);

        // Reset while a byte store sits in READ
        w0 = we_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h8, 32'h00000055, 1'b0, 1'b0, 32'h0, 0, "abort", 1'b0, w);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort req_ready low", 32'(bus.req_ready), 32'h0);
        check("abort mem_we",        32'(bus.mem_we),    32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort req_ready rel", 32'(bus.req_ready), 32'h1);
        repeat (4) @(negedge clk);
        check("abort we cycles", 32'(we_cnt - w0), 32'h0);
        check("abort mem[0x8]",  mem[2], 32'h8001AB78);

        // req_valid held high: same load accepted twice, back to back
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h8001AB78, 2, "ld_hold1", 1'b1, w);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h8001AB78, 2, "ld_hold2", 1'b0, w);
        check("hold ready-low cycles", 32'(w), 32'h2);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
